// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_unit
// Brief    : ID-stage operand bypass select, load-use / long-op stall and a
//            register scoreboard for out-of-order multi-cycle retirement.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard_unit #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int NUM_SRC          = 2,
  parameter int MAX_LONG         = 4,
  parameter int PERF_BITWIDTH    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  id_valid_i,
  input  logic [NUM_SRC*REG_NUM_BITWIDTH-1:0]   id_rs_i,
  input  logic [NUM_SRC-1:0]                    id_rs_used_i,
  input  logic [REG_NUM_BITWIDTH-1:0]           id_rd_i,
  input  logic                                  id_regWrite_i,
  input  logic                                  id_isLong_i,
  input  logic [REG_NUM_BITWIDTH-1:0]           ex_Rd_i,
  input  logic [REG_NUM_BITWIDTH-1:0]           mem_Rd_i,
  input  logic [REG_NUM_BITWIDTH-1:0]           wb_Rd_i,
  input  logic                                  ex_regWrite_i,
  input  logic                                  mem_regWrite_i,
  input  logic                                  wb_regWrite_i,
  input  logic                                  ex_isLoad_i,
  input  logic                                  long_done_i,
  input  logic [REG_NUM_BITWIDTH-1:0]           long_Rd_i,
  input  logic                                  flush_i,
  output logic [2*NUM_SRC-1:0]                  forward_o,
  output logic                                  stall_o,
  output logic                                  long_busy_o,
  output logic [PERF_BITWIDTH-1:0]              perf_stall_cnt_o,
  output logic                                  sb_err_o
);

  localparam int RNB      = REG_NUM_BITWIDTH;
  localparam int NUM_REGS = 2**RNB;
  localparam int CNT_W    = $clog2(MAX_LONG + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LONG);

  function automatic logic f_hit(input logic             we,
                                 input logic [RNB-1:0]   rd,
                                 input logic [RNB-1:0]   r);
    return we && (rd != '0) && (rd == r);
  endfunction

  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic [PERF_BITWIDTH-1:0] perf_q, perf_d;

  logic [NUM_SRC-1:0]       w_load_use;
  logic [NUM_SRC-1:0]       w_raw_long;
  logic                     w_waw_long;
  logic                     w_struct;
  logic                     w_issue;
  logic                     w_clr_ok;
  logic                     w_clr_bad;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [RNB-1:0] w_rs;
    logic           w_hit_ex, w_hit_mem, w_hit_wb;

    assign w_rs      = id_rs_i[gi*RNB +: RNB];
    assign w_hit_ex  = f_hit(ex_regWrite_i,  ex_Rd_i,  w_rs);
    assign w_hit_mem = f_hit(mem_regWrite_i, mem_Rd_i, w_rs);
    assign w_hit_wb  = f_hit(wb_regWrite_i,  wb_Rd_i,  w_rs);

    // Youngest producer wins: EX over MEM over WB.
    assign forward_o[2*gi +: 2] = w_hit_ex  ? 2'b10 :
                                  w_hit_mem ? 2'b01 :
                                  w_hit_wb  ? 2'b11 : 2'b00;

    assign w_load_use[gi] = id_rs_used_i[gi] && ex_isLoad_i && w_hit_ex;
    assign w_raw_long[gi] = id_rs_used_i[gi] && (w_rs != '0) && busy_q[w_rs];
  end

  // Stall is derived from registered scoreboard state only, so retirement
  // never reaches stall combinationally; the blocked reader goes next cycle.
  assign long_busy_o = (cnt_q == MAX_CNT);
  assign w_waw_long  = id_regWrite_i && (id_rd_i != '0) && busy_q[id_rd_i];
  assign w_struct    = id_isLong_i && long_busy_o;
  assign stall_o     = id_valid_i && !flush_i &&
                       ((|w_load_use) || (|w_raw_long) || w_waw_long || w_struct);

  assign w_issue   = id_valid_i && !flush_i && !stall_o && id_isLong_i &&
                     id_regWrite_i && (id_rd_i != '0);
  assign w_clr_ok  = long_done_i && (long_Rd_i != '0) &&  busy_q[long_Rd_i];
  assign w_clr_bad = long_done_i && (long_Rd_i != '0) && !busy_q[long_Rd_i];

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    perf_d = perf_q;
    if (w_clr_ok) busy_d[long_Rd_i] = 1'b0;
    if (w_issue)  busy_d[id_rd_i]   = 1'b1;
    case ({w_issue, w_clr_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (w_clr_bad) err_d = 1'b1;
    if (stall_o && (perf_q != {PERF_BITWIDTH{1'b1}})) perf_d = perf_q + PERF_BITWIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      perf_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt_o = perf_q;
  assign sb_err_o         = err_q;

endmodule
`default_nettype wire
